// File: rtl/cover_toggle_pkg.sv
// Shared types and helpers for the toggle-coverage detector.
// Holds the per-bit tracker state encoding and a saturating adder.
package cover_toggle_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROSE = 2'd1,
    FELL = 2'd2,
    DONE = 2'd3
  } bit_state_e;

  localparam int unsigned SatW = 32;

  // Counters up to SatW bits wide share this adder; callers pass their own ceiling.
  function automatic logic [SatW-1:0] satAdd(input logic [SatW-1:0] a,
                                              input logic [SatW-1:0] b,
                                              input logic [SatW-1:0] limit);
    logic [SatW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, limit}) begin
      return limit;
    end
    return sum[SatW-1:0];
  endfunction

endpackage

// File: rtl/cover_toggle_bit.sv
// Single-bit toggle tracker: fires once both a rise and a fall have been seen.
// With REPORT_ONCE the bit parks in DONE until cleared, otherwise it re-arms.
module cover_toggle_bit
  import cover_toggle_pkg::*;
#(
  parameter bit REPORT_ONCE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic rise,
  input  logic fall,
  input  logic clear,
  output logic fire
);

  bit_state_e state_q;
  bit_state_e state_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = ROSE;
          end else if (fall) begin
            state_d = FELL;
          end
        end
        ROSE: begin
          if (fall) begin
            state_d = REPORT_ONCE ? DONE : IDLE;
          end
        end
        FELL: begin
          if (rise) begin
            state_d = REPORT_ONCE ? DONE : IDLE;
          end
        end
        DONE: begin
          state_d = REPORT_ONCE ? DONE : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A completing edge that coincides with clear is dropped.
  always_comb begin
    fire = 1'b0;
    if (!clear) begin
      fire = ((state_q == ROSE) && fall) || ((state_q == FELL) && rise);
    end
  end

endmodule

// File: rtl/cover_toggle_detect.sv
// Toggle-coverage feeder: per-bit full-toggle pulses plus sticky hit map,
// saturating hit counter and an all-hit flag for coverage closure.
module cover_toggle_detect
  import cover_toggle_pkg::*;
#(
  parameter int unsigned WIDTH       = 9,
  parameter bit          REPORT_ONCE = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] valid,
  output logic [WIDTH-1:0] hit_map,
  output logic [CNT_W-1:0] hit_count,
  output logic             all_hit
);

  localparam logic [SatW-1:0] CntMax = {SatW{1'b1}} >> (SatW - CNT_W);

  logic [WIDTH-1:0] prev_q;
  logic             armed_q;
  logic [WIDTH-1:0] valid_q;
  logic [WIDTH-1:0] valid_d;
  logic [WIDTH-1:0] hitMap_q;
  logic [WIDTH-1:0] hitMap_d;
  logic [CNT_W-1:0] hitCount_q;
  logic [CNT_W-1:0] hitCount_d;

  logic             edgeGate;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] fire;
  logic [SatW-1:0]  fireCount;

  // The first cycle after reset only captures sig, so a level held high
  // through reset release is never mistaken for a rising edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= sig;
      armed_q <= 1'b1;
    end
  end

  assign edgeGate = armed_q & enable;
  assign rise     = {WIDTH{edgeGate}} & ~prev_q & sig;
  assign fall     = {WIDTH{edgeGate}} & prev_q & ~sig;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    cover_toggle_bit #(
      .REPORT_ONCE(REPORT_ONCE)
    ) u_bit (
      .clock(clock),
      .reset(reset),
      .rise (rise[i]),
      .fall (fall[i]),
      .clear(clear),
      .fire (fire[i])
    );
  end

  always_comb begin
    fireCount = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fireCount = fireCount + SatW'(fire[i]);
    end
  end

  always_comb begin
    valid_d    = '0;
    hitMap_d   = '0;
    hitCount_d = '0;
    if (!clear) begin
      valid_d    = fire;
      hitMap_d   = hitMap_q | fire;
      hitCount_d = CNT_W'(satAdd(SatW'(hitCount_q), fireCount, CntMax));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      hitMap_q   <= '0;
      hitCount_q <= '0;
    end else begin
      valid_q    <= valid_d;
      hitMap_q   <= hitMap_d;
      hitCount_q <= hitCount_d;
    end
  end

  assign valid     = valid_q;
  assign hit_map   = hitMap_q;
  assign hit_count = hitCount_q;
  assign all_hit   = &hitMap_q;

endmodule

// File: tb/tb_cover_toggle_detect.sv
// Scoreboard bench: three detector configurations share one random stimulus
// stream and are checked every cycle against a per-bit "seen rise / seen fall" model.
module tb_cover_toggle_detect;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       clear;
  logic [8:0] sig;

  logic [8:0]  valid0, valid1, valid2;
  logic [8:0]  hitMap0, hitMap1, hitMap2;
  logic [15:0] hc0, hc1;
  logic [3:0]  hc2;
  logic        allHit0, allHit1, allHit2;

  logic [2:0][8:0]  actValid;
  logic [2:0][8:0]  actHitMap;
  logic [2:0][15:0] actCount;
  logic [2:0]       actAllHit;

  typedef struct packed {
    logic [2:0][8:0]  valid;
    logic [2:0][8:0]  hitMap;
    logic [2:0][15:0] count;
    logic [2:0]       allHit;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: prev/armed are shared, coverage state is per configuration.
  logic [8:0] mPrev;
  bit         mArmed;
  bit         mSawRise[3][9];
  bit         mSawFall[3][9];
  bit         mDone[3][9];
  logic [8:0] mHitMap[3];
  logic [8:0] mValid[3];
  int         mCount[3];
  bit         mRo[3]  = '{1'b1, 1'b0, 1'b0};
  int         mMax[3] = '{65535, 65535, 15};

  always #5 clock = ~clock;

  cover_toggle_detect #(.WIDTH(9), .REPORT_ONCE(1'b1), .CNT_W(16)) dut0 (
    .clock(clock), .reset(reset), .sig(sig), .enable(enable), .clear(clear),
    .valid(valid0), .hit_map(hitMap0), .hit_count(hc0), .all_hit(allHit0)
  );

  cover_toggle_detect #(.WIDTH(9), .REPORT_ONCE(1'b0), .CNT_W(16)) dut1 (
    .clock(clock), .reset(reset), .sig(sig), .enable(enable), .clear(clear),
    .valid(valid1), .hit_map(hitMap1), .hit_count(hc1), .all_hit(allHit1)
  );

  cover_toggle_detect #(.WIDTH(9), .REPORT_ONCE(1'b0), .CNT_W(4)) dut2 (
    .clock(clock), .reset(reset), .sig(sig), .enable(enable), .clear(clear),
    .valid(valid2), .hit_map(hitMap2), .hit_count(hc2), .all_hit(allHit2)
  );

  assign actValid[0]  = valid0;
  assign actValid[1]  = valid1;
  assign actValid[2]  = valid2;
  assign actHitMap[0] = hitMap0;
  assign actHitMap[1] = hitMap1;
  assign actHitMap[2] = hitMap2;
  assign actCount[0]  = hc0;
  assign actCount[1]  = hc1;
  assign actCount[2]  = {12'h000, hc2};
  assign actAllHit[0] = allHit0;
  assign actAllHit[1] = allHit1;
  assign actAllHit[2] = allHit2;

  task automatic checkOutput(input string name, input int d,
                             input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s dut%0d actual=%h expected=%h at %0t", name, d, act, expv, $time);
    end
  endtask

  task automatic modelReset();
    mArmed = 1'b0;
    mPrev  = '0;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 9; i++) begin
        mSawRise[d][i] = 1'b0;
        mSawFall[d][i] = 1'b0;
        mDone[d][i]    = 1'b0;
      end
      mHitMap[d] = '0;
      mValid[d]  = '0;
      mCount[d]  = 0;
    end
  endtask

  task automatic modelStep(input logic [8:0] s, input bit en, input bit clr, output exp_t e);
    logic [8:0] fired;
    int sum;
    for (int d = 0; d < 3; d++) begin
      fired = '0;
      if (mArmed && en && !clr) begin
        for (int i = 0; i < 9; i++) begin
          if (!mDone[d][i]) begin
            if (!mPrev[i] && s[i]) mSawRise[d][i] = 1'b1;
            if (mPrev[i] && !s[i]) mSawFall[d][i] = 1'b1;
            if (mSawRise[d][i] && mSawFall[d][i]) begin
              fired[i]       = 1'b1;
              mSawRise[d][i] = 1'b0;
              mSawFall[d][i] = 1'b0;
              if (mRo[d]) mDone[d][i] = 1'b1;
            end
          end
        end
      end
      if (clr) begin
        for (int i = 0; i < 9; i++) begin
          mSawRise[d][i] = 1'b0;
          mSawFall[d][i] = 1'b0;
          mDone[d][i]    = 1'b0;
        end
        mHitMap[d] = '0;
        mValid[d]  = '0;
        mCount[d]  = 0;
      end else begin
        mValid[d]  = fired;
        mHitMap[d] = mHitMap[d] | fired;
        sum        = mCount[d] + $countones(fired);
        mCount[d]  = (sum > mMax[d]) ? mMax[d] : sum;
      end
      e.valid[d]  = mValid[d];
      e.hitMap[d] = mHitMap[d];
      e.count[d]  = 16'(mCount[d]);
      e.allHit[d] = (mHitMap[d] == 9'h1FF);
    end
    mPrev  = s;
    mArmed = 1'b1;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input logic [8:0] s, input bit en, input bit clr);
    exp_t e;
    sig    = s;
    enable = en;
    clear  = clr;
    modelStep(s, en, clr, e);
    expQ.push_back(e);
    @(negedge clock);
  endtask

  task automatic checkAllZero(input string tag);
    for (int d = 0; d < 3; d++) begin
      checkOutput({tag, "_valid"},   d, {7'h00, actValid[d]},  16'h0000);
      checkOutput({tag, "_hitmap"},  d, {7'h00, actHitMap[d]}, 16'h0000);
      checkOutput({tag, "_count"},   d, actCount[d],           16'h0000);
      checkOutput({tag, "_allhit"},  d, {15'h0000, actAllHit[d]}, 16'h0000);
    end
  endtask

  task automatic doReset();
    #2 reset = 1'b1;
    #1 checkAllZero("async_reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    modelReset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        for (int d = 0; d < 3; d++) begin
          checkOutput("valid",   d, {7'h00, actValid[d]},     {7'h00, e.valid[d]});
          checkOutput("hit_map", d, {7'h00, actHitMap[d]},    {7'h00, e.hitMap[d]});
          checkOutput("count",   d, actCount[d],              e.count[d]);
          checkOutput("all_hit", d, {15'h0000, actAllHit[d]}, {15'h0000, e.allHit[d]});
        end
      end
    end
  end

  initial begin : stimulus
    logic [8:0] s;
    reset  = 1'b1;
    sig    = 9'h1FF;
    enable = 1'b1;
    clear  = 1'b0;
    modelReset();
    @(negedge clock);
    #1 checkAllZero("reset_state");
    @(negedge clock);
    reset = 1'b0;

    // Stuck-high at release must not look like a rise.
    for (int n = 0; n < 20; n++) applyStimulus(9'h1FF, 1'b1, 1'b0);
    applyStimulus(9'h000, 1'b1, 1'b1);
    for (int n = 0; n < 3; n++) applyStimulus(9'h000, 1'b1, 1'b0);

    // Single full toggle of bit 0, then a repeat.
    applyStimulus(9'h001, 1'b1, 1'b0);
    applyStimulus(9'h001, 1'b1, 1'b0);
    applyStimulus(9'h001, 1'b1, 1'b0);
    applyStimulus(9'h000, 1'b1, 1'b0);
    applyStimulus(9'h000, 1'b1, 1'b0);
    applyStimulus(9'h001, 1'b1, 1'b0);
    applyStimulus(9'h000, 1'b1, 1'b0);
    applyStimulus(9'h000, 1'b1, 1'b0);

    // All bits toggle together.
    applyStimulus(9'h1FF, 1'b1, 1'b0);
    applyStimulus(9'h000, 1'b1, 1'b0);
    applyStimulus(9'h000, 1'b1, 1'b0);

    // Clear collides with the completing fall of bit 3.
    applyStimulus(9'h000, 1'b1, 1'b1);
    applyStimulus(9'h008, 1'b1, 1'b0);
    applyStimulus(9'h000, 1'b1, 1'b1);
    applyStimulus(9'h000, 1'b1, 1'b0);
    applyStimulus(9'h008, 1'b1, 1'b0);
    applyStimulus(9'h000, 1'b1, 1'b0);
    applyStimulus(9'h000, 1'b1, 1'b0);

    // Rise lost under enable=0, fall seen: bit 4 only half toggled.
    applyStimulus(9'h010, 1'b0, 1'b0);
    applyStimulus(9'h000, 1'b1, 1'b0);
    applyStimulus(9'h000, 1'b1, 1'b0);
    applyStimulus(9'h000, 1'b1, 1'b0);

    // Drive the 4-bit counter past its ceiling.
    for (int n = 0; n < 3; n++) begin
      applyStimulus(9'h1FF, 1'b1, 1'b0);
      applyStimulus(9'h000, 1'b1, 1'b0);
    end
    applyStimulus(9'h000, 1'b1, 1'b0);

    // Reset in the middle of a partial toggle.
    applyStimulus(9'h020, 1'b1, 1'b0);
    doReset();
    for (int n = 0; n < 3; n++) applyStimulus(9'h020, 1'b1, 1'b0);

    s = 9'h020;
    for (int n = 0; n < 600; n++) begin
      s = s ^ (9'($urandom) & 9'($urandom));
      applyStimulus(s, ($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0));
    end

    @(posedge clock);
    #3;
    checkOutput("queue_drained", 0, 16'(expQ.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
